pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_if.sv | 45 ++++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU package: pipeline-register widths, hazard-controller state
// encoding and the divider latency default.
package pipe_ctrl_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned FD_REG_W    = 2 * XLEN;
    localparam int unsigned DE_REG_W    = 4 * XLEN + 16;
    localparam int unsigned EM_REG_W    = 3 * XLEN + 8;
    localparam int unsigned MW_REG_W    = 2 * XLEN + 8;

    localparam int unsigned DIV_CYCLES_DEF = 32;
    localparam int unsigned CNT_W          = 6;
    localparam int unsigned STALL_CNT_W    = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV      = 2'd1,
        ST_DIV_DONE = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard requests from the pipeline and the enable/clear/divider controls
// returned by pipe_ctrl.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic if_stall;
    logic mem_stall;
    logic load_use;
    logic ex_div;
    logic exc_flush;

    logic pc_en;
    logic fd_en;
    logic de_en;
    logic em_en;
    logic mw_en;
    logic fd_clr;
    logic de_clr;
    logic em_clr;
    logic mw_clr;
    logic pc_exc;
    logic div_start;
    logic div_abort;
    logic div_busy;
    logic div_done;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // master = the hazard controller
    modport master (
        input  if_stall, mem_stall, load_use, ex_div, exc_flush,
        output pc_en, fd_en, de_en, em_en, mw_en,
        output fd_clr, de_clr, em_clr, mw_clr,
        output pc_exc, div_start, div_abort, div_busy, div_done,
        output stall_cnt
    );

    modport slave (
        output if_stall, mem_stall, load_use, ex_div, exc_flush,
        input  pc_en, fd_en, de_en, em_en, mw_en,
        input  fd_clr, de_clr, em_clr, mw_clr,
        input  pc_exc, div_start, div_abort, div_busy, div_done,
        input  stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritises flush/stall requests, sequences
// the multi-cycle divider freeze and counts PC-stalled cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master ctl
);

    pipe_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic pc_en, fd_en, de_en, em_en, mw_en;
    logic fd_clr, de_clr, em_clr, mw_clr;
    logic pc_exc, div_start, div_abort, div_busy, div_done;
    logic div_stall;

    assign div_stall = (state_q == ST_DIV) || ((state_q == ST_RUN) && ctl.ex_div);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        de_en     = 1'b0;
        em_en     = 1'b0;
        mw_en     = 1'b0;
        fd_clr    = 1'b0;
        de_clr    = 1'b0;
        em_clr    = 1'b0;
        mw_clr    = 1'b0;
        pc_exc    = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        div_busy  = 1'b0;
        div_done  = 1'b0;
        if (!rst) begin
            if (ctl.exc_flush) begin
                pc_en     = 1'b1;
                fd_en     = 1'b1;
                de_en     = 1'b1;
                em_en     = 1'b1;
                mw_en     = 1'b1;
                fd_clr    = 1'b1;
                de_clr    = 1'b1;
                em_clr    = 1'b1;
                mw_clr    = 1'b1;
                pc_exc    = 1'b1;
                div_abort = (state_q == ST_DIV);
                state_d   = ST_RUN;
                cnt_d     = '0;
            end else if (ctl.mem_stall) begin
                mw_en    = 1'b1;
                mw_clr   = 1'b1;
                div_busy = (state_q == ST_DIV);
                div_done = (state_q == ST_DIV_DONE);
            end else if (div_stall) begin
                em_en    = 1'b1;
                em_clr   = 1'b1;
                mw_en    = 1'b1;
                div_busy = 1'b1;
                // start cycle loads DIV_CYCLES-2 so the freeze spans exactly DIV_CYCLES cycles
                if (state_q == ST_RUN) begin
                    div_start = 1'b1;
                    cnt_d     = CNT_W'(DIV_CYCLES - 2);
                    state_d   = ST_DIV;
                end else if (cnt_q == '0) begin
                    state_d = ST_DIV_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                div_done = (state_q == ST_DIV_DONE);
                if (state_q == ST_DIV_DONE) begin
                    state_d = ST_RUN;
                end
                de_en = 1'b1;
                em_en = 1'b1;
                mw_en = 1'b1;
                if (ctl.load_use) begin
                    de_clr = 1'b1;
                end else if (ctl.if_stall) begin
                    fd_en  = 1'b1;
                    fd_clr = 1'b1;
                end else begin
                    pc_en = 1'b1;
                    fd_en = 1'b1;
                end
            end
        end
    end

    assign stall_cnt_d = pc_en ? stall_cnt_q : stall_cnt_q + STALL_CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctl.pc_en     = pc_en;
    assign ctl.fd_en     = fd_en;
    assign ctl.de_en     = de_en;
    assign ctl.em_en     = em_en;
    assign ctl.mw_en     = mw_en;
    assign ctl.fd_clr    = fd_clr;
    assign ctl.de_clr    = de_clr;
    assign ctl.em_clr    = em_clr;
    assign ctl.mw_clr    = mw_clr;
    assign ctl.pc_exc    = pc_exc;
    assign ctl.div_start = div_start;
    assign ctl.div_abort = div_abort;
    assign ctl.div_busy  = div_busy;
    assign ctl.div_done  = div_done;
    assign ctl.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios plus random requests, all
// compared against a freeze-cycle-budget model of the controller.
module tb_pipe_ctrl;

    localparam int unsigned DIVC = 32;

    logic clk;
    logic rst;

    pipe_ctrl_if ctl ();

    pipe_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (ctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int          cyc      = 0;
    int          done_cyc = -1;
    int          start_cyc = -1;

    // stimulus registers applied on the next tick
    logic r_rst, r_if, r_mem, r_lu, r_ex, r_exc;

    // model: divide in progress, freeze cycles still owed, result pending
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int unsigned m_left = 0;
    logic [31:0] m_sc   = '0;

    // {pc,fd,de,em,mw}_en, {fd,de,em,mw}_clr, pc_exc, start, abort, busy, done
    logic [13:0] obs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        logic [13:0] e;
        logic [8:0]  pat;
        bit          start;
        bit          nb, nd;
        int unsigned nl;
        logic [31:0] nsc;
        @(negedge clk);
        rst           = r_rst;
        ctl.if_stall  = r_if;
        ctl.mem_stall = r_mem;
        ctl.load_use  = r_lu;
        ctl.ex_div    = r_ex;
        ctl.exc_flush = r_exc;
        #1;
        nb = m_busy;
        nd = m_done;
        nl = m_left;
        e  = '0;
        if (r_rst) begin
            nb = 1'b0; nd = 1'b0; nl = 0; m_sc = '0;
        end else if (r_exc) begin
            e  = {5'b11111, 4'b1111, 1'b1, 1'b0, m_busy, 1'b0, 1'b0};
            nb = 1'b0; nd = 1'b0; nl = 0;
        end else if (r_mem) begin
            e  = {5'b00001, 4'b0001, 1'b0, 1'b0, 1'b0, m_busy, m_done};
        end else if (m_busy || (!m_done && r_ex)) begin
            start = !m_busy;
            e  = {5'b00011, 4'b0010, 1'b0, start, 1'b0, 1'b1, 1'b0};
            nl = start ? DIVC - 1 : m_left - 1;
            if (nl == 0) begin
                nb = 1'b0; nd = 1'b1;
            end else begin
                nb = 1'b1;
            end
        end else begin
            if (r_lu)      pat = {5'b00111, 4'b0100};
            else if (r_if) pat = {5'b01111, 4'b1000};
            else           pat = {5'b11111, 4'b0000};
            e  = {pat, 4'b0000, m_done};
            nd = 1'b0;
        end
        obs = {ctl.pc_en, ctl.fd_en, ctl.de_en, ctl.em_en, ctl.mw_en,
               ctl.fd_clr, ctl.de_clr, ctl.em_clr, ctl.mw_clr,
               ctl.pc_exc, ctl.div_start, ctl.div_abort, ctl.div_busy, ctl.div_done};
        check("ctl_out", {18'd0, obs}, {18'd0, e});
        check("stall_cnt", ctl.stall_cnt, m_sc);
        if (obs[0] && done_cyc < 0)  done_cyc  = cyc;
        if (obs[3] && start_cyc < 0) start_cyc = cyc;
        nsc = (!r_rst && !e[13]) ? m_sc + 32'd1 : m_sc;
        @(posedge clk);
        m_busy = nb;
        m_done = nd;
        m_left = nl;
        m_sc   = nsc;
        cyc++;
    endtask

    task automatic scn_reset();
        {r_if, r_mem, r_lu, r_ex, r_exc} = '0;
        r_rst = 1'b1;
        tick();
        r_rst     = 1'b0;
        cyc       = 0;
        done_cyc  = -1;
        start_cyc = -1;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        rst = 1'b1;
        {ctl.if_stall, ctl.mem_stall, ctl.load_use, ctl.ex_div, ctl.exc_flush} = '0;
        {r_if, r_mem, r_lu, r_ex, r_exc} = '0;
        r_rst = 1'b1;

        // idle
        scn_reset();
        run_until(10);
        check("idle_out", {18'd0, obs}, {18'd0, 5'b11111, 9'd0});
        check("idle_cnt", ctl.stall_cnt, 32'd0);

        // single divide starting at cycle 5
        scn_reset();
        run_until(5);
        r_ex = 1'b1;
        while (done_cyc < 0 && cyc < 200) tick();
        r_ex = 1'b0;
        check("div_start_cyc", start_cyc, 5);
        check("div_done_cyc", done_cyc, 37);
        check("div_stall_cnt", ctl.stall_cnt, 32'd32);

        // mem_stall for cycles 10..12 during the divide
        scn_reset();
        run_until(5);
        r_ex = 1'b1;
        while (done_cyc < 0 && cyc < 200) begin
            r_mem = (cyc >= 10 && cyc <= 12);
            tick();
            if (cyc == 11) check("mem_mwclr", {31'd0, obs[5]}, 32'd1);
        end
        r_ex  = 1'b0;
        r_mem = 1'b0;
        check("mem_done_cyc", done_cyc, 40);
        check("mem_stall_cnt", ctl.stall_cnt, 32'd35);

        // exception during the divide at cycle 12
        scn_reset();
        run_until(5);
        r_ex = 1'b1;
        run_until(12);
        r_exc = 1'b1;
        tick();
        check("exc_abort", {26'd0, obs[2], obs[4], obs[8:5]}, 32'h3f);
        r_exc = 1'b0;
        r_ex  = 1'b0;
        tick();
        check("exc_run", {29'd0, obs[3], obs[1], obs[13]}, 32'd1);

        // simultaneous load_use, if_stall, mem_stall
        scn_reset();
        tick();
        {r_lu, r_if, r_mem} = 3'b111;
        tick();
        check("simul_mem", {18'd0, obs}, {18'd0, 5'b00001, 4'b0001, 5'd0});
        r_mem = 1'b0;
        tick();
        check("simul_lu", {30'd0, obs[7], obs[12]}, 32'd2);
        {r_lu, r_if} = 2'b00;

        // reset at cycle 20 during the divide
        scn_reset();
        run_until(5);
        r_ex = 1'b1;
        run_until(20);
        r_rst = 1'b1;
        tick();
        check("rst_out", {18'd0, obs}, 32'd0);
        check("rst_cnt", ctl.stall_cnt, 32'd0);
        r_rst = 1'b0;
        r_ex  = 1'b0;
        tick();
        check("rst_run", {27'd0, obs[13:9]}, 32'h1f);

        // random requests, ex_div held as a level while the divide is frozen
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_exc = ($urandom_range(0, 59) == 0);
            r_mem = ($urandom_range(0, 5) == 0);
            r_lu  = ($urandom_range(0, 4) == 0);
            r_if  = ($urandom_range(0, 4) == 0);
            r_ex  = m_busy ? 1'b1 : ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
